// File: rtl/branch_ctrl_pkg.sv
// Shared types and encodings for the branch sequencing controller.
// Used by branch_flush_ctrl and its optional performance counters.
package branch_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ   = 2'b00;
    localparam logic [1:0] PC_SEL_PRED  = 2'b01;
    localparam logic [1:0] PC_SEL_RECOV = 2'b10;

    // State plus the record kept for the branch waiting to resolve in EX.
    typedef struct packed {
        state_e state;
        logic   pred_taken;
    } ctrl_t;

endpackage : branch_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Only instantiated when BRANCH_PERF_EN is defined.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/branch_flush_ctrl.sv
// Branch sequencing controller: PC steering, mispredict recovery, predictor training
// and stall/flush arbitration. Define BRANCH_PERF_EN to build the branch/mispredict counters.
module branch_flush_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_branch_i,
    input  logic [ADDR_W-1:0] id_pc_i,
    input  logic [ADDR_W-1:0] id_target_i,
    input  logic              predict_i,
    input  logic              ex_taken_i,
    input  logic              stall_i,
    output logic [1:0]        pc_sel_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              flush_ifid_o,
    output logic              flush_idex_o,
    output logic              upd_valid_o,
    output logic              upd_taken_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    state_e            state_d,       state_q;
    logic              pred_taken_d,  pred_taken_q;
    logic [ADDR_W-1:0] fallback_pc_d, fallback_pc_q;

    logic              in_pend;
    logic              mispredict;
    logic              capture;

    logic [1:0]        pc_sel;
    logic [ADDR_W-1:0] redirect_pc;
    logic              pc_write;
    logic              ifid_write;
    logic              flush_ifid;
    logic              flush_idex;
    logic              upd_valid;
    logic              upd_taken;

    assign in_pend    = (state_q == PEND);
    assign mispredict = in_pend && (ex_taken_i != pred_taken_q);
    // A branch sitting in ID during a mispredict is on the wrong path.
    assign capture    = id_branch_i && !stall_i && !mispredict;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = IDLE;
        pred_taken_d  = pred_taken_q;
        fallback_pc_d = fallback_pc_q;

        pc_sel        = PC_SEL_SEQ;
        redirect_pc   = '0;
        pc_write      = !stall_i;
        ifid_write    = !stall_i;
        flush_ifid    = 1'b0;
        flush_idex    = stall_i;
        upd_valid     = in_pend;
        upd_taken     = in_pend && ex_taken_i;

        if (capture) begin
            state_d       = PEND;
            pred_taken_d  = predict_i;
            fallback_pc_d = predict_i ? (id_pc_i + ADDR_W'(4)) : id_target_i;
            if (predict_i) begin
                pc_sel      = PC_SEL_PRED;
                redirect_pc = id_target_i;
                flush_ifid  = 1'b1;
            end
        end

        // Recovery overrides both the stall and any ID-stage redirect.
        if (mispredict) begin
            pc_sel      = PC_SEL_RECOV;
            redirect_pc = fallback_pc_q;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            // NOTE: the branch record is reset too, so nothing stale is visible after reset.
            state_q       <= IDLE;
            pred_taken_q  <= 1'b0;
            fallback_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pred_taken_q  <= pred_taken_d;
            fallback_pc_q <= fallback_pc_d;
        end
    end

    // While reset is held the pipeline keeps loading with no redirects or flushes.
    assign pc_sel_o      = rst_i ? PC_SEL_SEQ : pc_sel;
    assign redirect_pc_o = rst_i ? '0         : redirect_pc;
    assign pc_write_o    = rst_i ? 1'b1       : pc_write;
    assign ifid_write_o  = rst_i ? 1'b1       : ifid_write;
    assign flush_ifid_o  = !rst_i && flush_ifid;
    assign flush_idex_o  = !rst_i && flush_idex;
    assign upd_valid_o   = !rst_i && upd_valid;
    assign upd_taken_o   = !rst_i && upd_taken;

`ifdef BRANCH_PERF_EN
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (upd_valid),
        .cnt_o   (branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (mispredict),
        .cnt_o   (mispred_cnt)
    );

    assign branch_cnt_o  = rst_i ? '0 : branch_cnt;
    assign mispred_cnt_o = rst_i ? '0 : mispred_cnt;
`else
    assign branch_cnt_o  = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule : branch_flush_ctrl

// File: tb/tb_branch_flush_ctrl.sv
// Directed, table-driven bench for branch_flush_ctrl (ADDR_W = 32, CNT_W = 2).
// Counter expectations apply when BRANCH_PERF_EN is defined, otherwise they must read 0.
module tb_branch_flush_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;
`ifdef BRANCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i;
    logic              id_branch_i;
    logic [ADDR_W-1:0] id_pc_i;
    logic [ADDR_W-1:0] id_target_i;
    logic              predict_i;
    logic              ex_taken_i;
    logic              stall_i;
    logic [1:0]        pc_sel_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              flush_ifid_o;
    logic              flush_idex_o;
    logic              upd_valid_o;
    logic              upd_taken_o;
    logic [CNT_W-1:0]  branch_cnt_o;
    logic [CNT_W-1:0]  mispred_cnt_o;

    branch_flush_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_branch_i   (id_branch_i),
        .id_pc_i       (id_pc_i),
        .id_target_i   (id_target_i),
        .predict_i     (predict_i),
        .ex_taken_i    (ex_taken_i),
        .stall_i       (stall_i),
        .pc_sel_o      (pc_sel_o),
        .redirect_pc_o (redirect_pc_o),
        .pc_write_o    (pc_write_o),
        .ifid_write_o  (ifid_write_o),
        .flush_ifid_o  (flush_ifid_o),
        .flush_idex_o  (flush_idex_o),
        .upd_valid_o   (upd_valid_o),
        .upd_taken_o   (upd_taken_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    // One vector = one clock cycle of inputs plus the outputs expected before that edge.
    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        ex;
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] redir;
        logic        pcw;
        logic        ifw;
        logic        fifid;
        logic        fidex;
        logic        updv;
        logic        updt;
        logic [1:0]  bcnt;
        logic [1:0]  mcnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic ex, input logic stall,
                       input logic [1:0] sel, input logic [31:0] redir, input logic pcw, input logic ifw,
                       input logic fifid, input logic fidex, input logic updv, input logic updt,
                       input logic [1:0] bcnt, input logic [1:0] mcnt);
        vec_t v;
        v = '{rst, br, pc, tgt, pred, ex, stall, sel, redir, pcw, ifw, fifid, fidex, updv, updt, bcnt, mcnt};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic rst, input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic ex, input logic stall);
        rst_i       = rst;
        id_branch_i = br;
        id_pc_i     = pc;
        id_target_i = tgt;
        predict_i   = pred;
        ex_taken_i  = ex;
        stall_i     = stall;
    endtask

    function automatic logic [63:0] pack_out();
        return {24'd0, pc_sel_o, redirect_pc_o, pc_write_o, ifid_write_o,
                flush_ifid_o, flush_idex_o, upd_valid_o, upd_taken_o};
    endfunction

    initial begin
        //   rst br pc            tgt          pr ex st | sel   redir        pw iw fi fx uv ut bc mc
        add(1, 1, 32'h40,       32'h80,      1, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 0, 0); // 0 reset
        add(0, 0, 32'h0,        32'h0,       0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 0, 0); // 1 idle
        add(0, 1, 32'h40,       32'h80,      1, 0, 0,  2'd1, 32'h80,      1, 1, 1, 0, 0, 0, 0, 0); // 2 pred taken
        add(0, 0, 32'h0,        32'h0,       0, 1, 0,  2'd0, 32'h0,       1, 1, 0, 0, 1, 1, 0, 0); // 3 correct
        add(0, 1, 32'h40,       32'h80,      1, 0, 0,  2'd1, 32'h80,      1, 1, 1, 0, 0, 0, 1, 0); // 4 pred taken
        add(0, 0, 32'h0,        32'h0,       0, 0, 0,  2'd2, 32'h44,      1, 1, 1, 1, 1, 0, 1, 0); // 5 not taken
        add(0, 1, 32'hC0,       32'h100,     0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 2, 1); // 6 pred NT
        add(0, 0, 32'h0,        32'h0,       0, 1, 0,  2'd2, 32'h100,     1, 1, 1, 1, 1, 1, 2, 1); // 7 taken
        add(0, 1, 32'h200,      32'h300,     1, 0, 1,  2'd0, 32'h0,       0, 0, 0, 1, 0, 0, 3, 2); // 8 stall
        add(0, 1, 32'h200,      32'h300,     1, 0, 0,  2'd1, 32'h300,     1, 1, 1, 0, 0, 0, 3, 2); // 9 retry
        add(0, 0, 32'h0,        32'h0,       0, 1, 0,  2'd0, 32'h0,       1, 1, 0, 0, 1, 1, 3, 2); // 10 correct
        add(0, 1, 32'h400,      32'h500,     0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 3, 2); // 11 pred NT
        add(0, 1, 32'h500,      32'h600,     1, 1, 1,  2'd2, 32'h500,     1, 1, 1, 1, 1, 1, 3, 2); // 12 mispred+stall+br
        add(0, 0, 32'h0,        32'h0,       0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 3, 3); // 13 back in IDLE
        add(0, 1, 32'h600,      32'h700,     1, 0, 0,  2'd1, 32'h700,     1, 1, 1, 0, 0, 0, 3, 3); // 14 pred taken
        add(0, 1, 32'h700,      32'h800,     0, 1, 0,  2'd0, 32'h0,       1, 1, 0, 0, 1, 1, 3, 3); // 15 back-to-back
        add(0, 0, 32'h0,        32'h0,       0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 1, 0, 3, 3); // 16 correct NT
        add(0, 0, 32'h0,        32'h0,       0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 3, 3); // 17 idle
        add(0, 1, 32'hFFFFFFFC, 32'h10,      1, 0, 0,  2'd1, 32'h10,      1, 1, 1, 0, 0, 0, 3, 3); // 18 wrap pc
        add(0, 0, 32'h0,        32'h0,       0, 0, 0,  2'd2, 32'h0,       1, 1, 1, 1, 1, 0, 3, 3); // 19 pc+4 wraps
        add(0, 1, 32'h40,       32'h80,      1, 0, 0,  2'd1, 32'h80,      1, 1, 1, 0, 0, 0, 3, 3); // 20 capture
        add(1, 0, 32'h0,        32'h0,       0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 0, 0); // 21 reset in PEND
        add(0, 0, 32'h0,        32'h0,       0, 0, 0,  2'd0, 32'h0,       1, 1, 0, 0, 0, 0, 0, 0); // 22 dropped

        drive(1, 0, '0, '0, 0, 0, 0);
        @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #2;
            drive(vecs[i].rst, vecs[i].br, vecs[i].pc, vecs[i].tgt, vecs[i].pred, vecs[i].ex, vecs[i].stall);
            @(negedge clk);
            check($sformatf("vec%0d_outputs", i), pack_out(),
                  {24'd0, vecs[i].sel, vecs[i].redir, vecs[i].pcw, vecs[i].ifw,
                   vecs[i].fifid, vecs[i].fidex, vecs[i].updv, vecs[i].updt});
            check($sformatf("vec%0d_counters", i), {60'd0, branch_cnt_o, mispred_cnt_o},
                  PERF ? {60'd0, vecs[i].bcnt, vecs[i].mcnt} : 64'd0);
        end

        // Three predicted-taken branches back to back, each resolving correctly.
        for (int k = 0; k < 4; k++) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(k) * 32'h10;
            @(posedge clk);
            #2;
            if (k < 3) drive(0, 1, pc, pc + 32'h100, 1, (k > 0), 0);
            else       drive(0, 0, '0, '0, 0, 1, 0);
            @(negedge clk);
            check($sformatf("b2b%0d_pc_sel", k), {62'd0, pc_sel_o}, (k < 3) ? 64'd1 : 64'd0);
            check($sformatf("b2b%0d_upd", k), {62'd0, upd_valid_o, flush_idex_o}, (k > 0) ? 64'd2 : 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_branch_flush_ctrl
